// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// The FSM state encoding and the default operand width live here.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/seq_divider_ripple_adder.sv
// N-bit ripple-carry adder built from a chain of 1-bit full-adder cells.
// The divider uses it as a subtractor by feeding B = ~M and Cin = 1.
module ripple_adder #(
  parameter int N = 9
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout
);

  logic [N:0] carry;

  assign carry[0] = Cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign Sum[i]     = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign Cout = carry[N];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock through
// a shared WIDTH+1-bit ripple subtractor; results delivered on a done pulse.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t state, state_nxt;

  // Partial remainder A is kept WIDTH bits wide: after every restore or
  // update its top bit is provably zero, so only the low bits are stored.
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   trial;
  logic             trial_cout;
  logic             keep;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             last_iter;

  // Shift stage: {A,Q} << 1, then trial subtract A_shifted - M
  assign a_sh = {acc, q_reg[WIDTH-1]};

  ripple_adder #(
    .N (WIDTH + 1)
  ) u_sub (
    .A    (a_sh),
    .B    (~{1'b0, m_reg}),
    .Cin  (1'b1),
    .Sum  (trial),
    .Cout (trial_cout)
  );

  // No borrow: sign bit clear and carry out set agree whenever A_shifted >= M.
  assign keep      = ~trial[WIDTH] & trial_cout;
  assign a_nxt     = keep ? trial[WIDTH-1:0] : a_sh[WIDTH-1:0];
  assign q_nxt     = {q_reg[WIDTH-2:0], keep};
  assign last_iter = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_nxt = (divisor == '0) ? DONE : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        if (start) begin
          state_nxt = (divisor == '0) ? DONE : RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          acc   <= a_nxt;
          q_reg <= q_nxt;
          cnt   <= cnt - CW'(1);
          if (last_iter) begin
            quotient  <= q_nxt;
            remainder <= a_nxt;
          end
        end
        default: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              acc         <= '0;
              q_reg       <= dividend;
              m_reg       <= divisor;
              cnt         <= CW'(WIDTH);
              div_by_zero <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider at WIDTH 4, 8 and 16 against a plain
// arithmetic reference (a/b, a%b, divide-by-zero rule) and cycle timing.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        st4 = 1'b0, st8 = 1'b0, st16 = 1'b0;
  logic [3:0]  dd4 = '0, dv4 = '0;
  logic [7:0]  dd8 = '0, dv8 = '0;
  logic [15:0] dd16 = '0, dv16 = '0;
  logic        b4, b8, b16, d4, d8, d16, z4, z8, z16;
  logic [3:0]  q4, r4;
  logic [7:0]  q8, r8;
  logic [15:0] q16, r16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(4)) u_div4 (
    .clk(clk), .rst(rst), .start(st4), .dividend(dd4), .divisor(dv4),
    .busy(b4), .done(d4), .quotient(q4), .remainder(r4), .div_by_zero(z4));

  seq_divider #(.WIDTH(8)) u_div8 (
    .clk(clk), .rst(rst), .start(st8), .dividend(dd8), .divisor(dv8),
    .busy(b8), .done(d8), .quotient(q8), .remainder(r8), .div_by_zero(z8));

  seq_divider #(.WIDTH(16)) u_div16 (
    .clk(clk), .rst(rst), .start(st16), .dividend(dd16), .divisor(dv16),
    .busy(b16), .done(d16), .quotient(q16), .remainder(r16), .div_by_zero(z16));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input int w);
    case (w)
      4:       return d4;
      16:      return d16;
      default: return d8;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      4:       return b4;
      16:      return b16;
      default: return b8;
    endcase
  endfunction

  function automatic logic [63:0] q_of(input int w);
    case (w)
      4:       return 64'(q4);
      16:      return 64'(q16);
      default: return 64'(q8);
    endcase
  endfunction

  function automatic logic [63:0] r_of(input int w);
    case (w)
      4:       return 64'(r4);
      16:      return 64'(r16);
      default: return 64'(r8);
    endcase
  endfunction

  function automatic logic z_of(input int w);
    case (w)
      4:       return z4;
      16:      return z16;
      default: return z8;
    endcase
  endfunction

  task automatic set_in(input int w, input logic s, input logic [63:0] a, input logic [63:0] b);
    case (w)
      4:       begin st4 = s;  dd4 = a[3:0];   dv4 = b[3:0];   end
      16:      begin st16 = s; dd16 = a[15:0]; dv16 = b[15:0]; end
      default: begin st8 = s;  dd8 = a[7:0];   dv8 = b[7:0];   end
    endcase
  endtask

  // One complete division on instance w, checked for latency, busy span,
  // results, the arithmetic invariant and result hold after the pulse.
  task automatic divide(input int w, input logic [63:0] a, input logic [63:0] b,
                        input string tag);
    logic [63:0] mask, eq, er;
    int lat, busy_n;
    bit ovl;
    mask = (64'd1 << w) - 64'd1;
    eq   = (b == 0) ? mask : a / b;
    er   = (b == 0) ? a : a % b;
    set_in(w, 1'b1, a, b);
    tick();
    set_in(w, 1'b0, a, b);
    lat    = 1;
    busy_n = 0;
    ovl    = 1'b0;
    while (done_of(w) !== 1'b1 && lat < 60) begin
      if (busy_of(w) === 1'b1) busy_n++;
      tick();
      lat++;
    end
    if (done_of(w) === 1'b1 && busy_of(w) === 1'b1) ovl = 1'b1;
    chk($sformatf("%s_done", tag), 64'(done_of(w)), 64'd1);
    chk($sformatf("%s_lat", tag), 64'(lat), (b == 0) ? 64'd1 : 64'(w + 1));
    chk($sformatf("%s_busy_cycles", tag), 64'(busy_n), (b == 0) ? 64'd0 : 64'(w));
    chk($sformatf("%s_overlap", tag), 64'(ovl), 64'd0);
    chk($sformatf("%s_q", tag), q_of(w), eq);
    chk($sformatf("%s_r", tag), r_of(w), er);
    chk($sformatf("%s_dbz", tag), 64'(z_of(w)), (b == 0) ? 64'd1 : 64'd0);
    if (b != 0) begin
      chk($sformatf("%s_inv", tag), q_of(w) * b + r_of(w), a);
      chk($sformatf("%s_rem_lt", tag), 64'(r_of(w) < b), 64'd1);
    end
    tick();
    chk($sformatf("%s_pulse_end", tag), 64'(done_of(w)), 64'd0);
    chk($sformatf("%s_hold_q", tag), q_of(w), eq);
  endtask

  initial begin
    int lat;
    bit flag;
    logic [63:0] ra, rb;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy", 64'(b8), 64'd0);
    chk("rst_done", 64'(d8), 64'd0);
    chk("rst_q", 64'(q8), 64'd0);
    chk("rst_r", 64'(r8), 64'd0);
    chk("rst_dbz", 64'(z8), 64'd0);
    tick();

    // Directed WIDTH=8 cases
    divide(8, 100, 7, "d100_7");
    divide(8, 255, 1, "d255_1");
    divide(8, 5, 9, "d5_9");
    divide(8, 255, 255, "d255_255");
    divide(8, 0, 3, "d0_3");
    divide(8, 37, 0, "d37_0");
    divide(8, 9, 4, "after_dbz");

    // Start while running is ignored
    set_in(8, 1'b1, 200, 13);
    tick();
    set_in(8, 1'b0, 200, 13);
    lat = 1;
    repeat (3) begin tick(); lat++; end
    set_in(8, 1'b1, 9, 3);
    tick();
    lat++;
    set_in(8, 1'b0, 9, 3);
    while (d8 !== 1'b1 && lat < 60) begin tick(); lat++; end
    chk("ign_lat", 64'(lat), 64'd9);
    chk("ign_q", 64'(q8), 64'd15);
    chk("ign_r", 64'(r8), 64'd5);
    tick();
    chk("ign_no_second_done", 64'(d8), 64'd0);
    chk("ign_idle", 64'(b8), 64'd0);

    // Reset in flight discards the operation
    set_in(8, 1'b1, 200, 13);
    tick();
    set_in(8, 1'b0, 200, 13);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 64'(b8), 64'd0);
    chk("mid_rst_done", 64'(d8), 64'd0);
    chk("mid_rst_q", 64'(q8), 64'd0);
    chk("mid_rst_r", 64'(r8), 64'd0);
    chk("mid_rst_dbz", 64'(z8), 64'd0);
    flag = 1'b0;
    repeat (12) begin
      tick();
      if (d8 !== 1'b0 || b8 !== 1'b0) flag = 1'b1;
    end
    chk("mid_rst_quiet", 64'(flag), 64'd0);
    divide(8, 50, 6, "post_rst");

    // Back-to-back: second start accepted in the DONE cycle
    set_in(8, 1'b1, 100, 7);
    tick();
    set_in(8, 1'b0, 100, 7);
    lat = 1;
    while (d8 !== 1'b1 && lat < 60) begin tick(); lat++; end
    chk("b2b_lat1", 64'(lat), 64'd9);
    chk("b2b_q1", 64'(q8), 64'd14);
    chk("b2b_r1", 64'(r8), 64'd2);
    set_in(8, 1'b1, 77, 10);
    tick();
    lat++;
    set_in(8, 1'b0, 77, 10);
    chk("b2b_busy2", 64'(b8), 64'd1);
    while (d8 !== 1'b1 && lat < 80) begin tick(); lat++; end
    chk("b2b_lat2", 64'(lat), 64'd18);
    chk("b2b_q2", 64'(q8), 64'd7);
    chk("b2b_r2", 64'(r8), 64'd7);
    tick();

    // Random sweeps at WIDTH 4 and 16
    for (int i = 0; i < 30; i++) begin
      ra = 64'($urandom_range(0, 15));
      rb = 64'($urandom_range(0, 15));
      divide(4, ra, rb, $sformatf("w4_%0d", i));
    end
    for (int i = 0; i < 30; i++) begin
      ra = 64'($urandom_range(0, 65535));
      if (i % 3 == 0) rb = 64'($urandom_range(1, 20));
      else if (i == 7) rb = 64'd0;
      else rb = 64'($urandom_range(0, 65535));
      divide(16, ra, rb, $sformatf("w16_%0d", i));
    end
    divide(16, 65535, 65535, "w16_max");
    divide(4, 15, 1, "w4_max");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
